// File: rtl/delay_timer_datapath_if.sv
// Handshake between the start-pattern/control FSM and the timer datapath.
// The FSM drives the serial delay bit and phase strobes; the datapath returns the count and its done flag.
interface delay_timer_datapath_if #(
  parameter int DELAY_W = 4
);
  logic               data;
  logic               shift_ena;
  logic               counting;
  logic [DELAY_W-1:0] count;
  logic               done_counting;

  modport master (
    output data, shift_ena, counting,
    input  count, done_counting
  );

  modport slave (
    input  data, shift_ena, counting,
    output count, done_counting
  );
endinterface

// File: rtl/delay_timer_datapath.sv
// Timer datapath: shifts in a delay MSB-first, then counts down (delay+1) units of TICKS_PER_UNIT cycles.
// count mirrors the delay register; done_counting flags the final counting cycle.
module delay_timer_datapath #(
  parameter int DELAY_W        = 4,
  parameter int TICKS_PER_UNIT = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  delay_timer_datapath_if.slave  bus
);

  localparam int            PW       = $clog2(TICKS_PER_UNIT);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_UNIT - 1);

  logic [DELAY_W-1:0] dly_q;
  logic [DELAY_W-1:0] dly_d;
  logic [PW-1:0]      pre_q;
  logic [PW-1:0]      pre_d;
  logic [DELAY_W-1:0] shifted_s;
  logic               tc_s;
  logic               dly_zero_s;

  // A one-bit delay register has no older bits to keep, so the new bit replaces it outright.
  generate
    if (DELAY_W == 1) begin : g_shift_one
      assign shifted_s = bus.data;
    end else begin : g_shift_wide
      assign shifted_s = {dly_q[DELAY_W-2:0], bus.data};
    end
  endgenerate

  assign tc_s       = (pre_q == PRE_LAST);
  assign dly_zero_s = (dly_q == {DELAY_W{1'b0}});

  // Next-state selection: shift beats counting, and the prescaler clears whenever it is not advancing.
  always_comb begin
    dly_d = dly_q;
    pre_d = {PW{1'b0}};
    if (bus.shift_ena) begin
      dly_d = shifted_s;
    end else if (bus.counting) begin
      if (!tc_s) begin
        pre_d = pre_q + PW'(1);
      end else if (!dly_zero_s) begin
        dly_d = dly_q - DELAY_W'(1);
      end else begin
        dly_d = dly_q;
      end
    end else begin
      dly_d = dly_q;
    end
  end

  // State registers with immediate asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly_q <= {DELAY_W{1'b0}};
      pre_q <= {PW{1'b0}};
    end else begin
      dly_q <= dly_d;
      pre_q <= pre_d;
    end
  end

  assign bus.count         = dly_q;
  assign bus.done_counting = bus.counting & ~bus.shift_ena & tc_s & dly_zero_s;

endmodule
